result_sig_collector: RTL



---
 rtl/result_sig_collector.sv | 94 +++++++++
 1 files changed

// File: rtl/result_sig_collector.sv
// Result-word collector: DEPTH-entry valid/ready FIFO plus a running signature and saturating word count.
// Define SIG_MISR_EN for a rotate-then-XOR signature; otherwise the signature is a plain XOR accumulator.
module result_sig_collector #(
  parameter int DATA_W = 37,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              clear,
  output logic [DATA_W-1:0] sig,
  output logic [CNT_W-1:0]  word_count,
  output logic              overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [OCC_W-1:0]  occ;

  logic              push;
  logic              pop;
  logic [DATA_W-1:0] sig_base;
  logic [DATA_W-1:0] sig_upd;
  logic [CNT_W-1:0]  cnt_base;
  logic [CNT_W-1:0]  cnt_next;
  logic              ovf_next;

  // Handshake flags depend only on the occupancy register, never on in_valid/out_ready.
  assign in_ready  = (occ != OCC_W'(DEPTH));
  assign out_valid = (occ != '0);
  assign out_data  = mem[rd_ptr];

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      occ <= occ + OCC_W'(1);
      else if (pop && !push) occ <= occ - OCC_W'(1);
    end
  end

  // NOTE: storage has no reset; only pointers/occupancy define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // A clear in the same cycle as an accept folds the new word into an already-cleared state.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    sig_base = clear ? '0 : sig;
    cnt_base = clear ? '0 : word_count;
`ifdef SIG_MISR_EN
    sig_upd  = {sig_base[DATA_W-2:0], sig_base[DATA_W-1]} ^ in_data;
`else
    sig_upd  = sig_base ^ in_data;
`endif
    cnt_next = cnt_base;
    if (push && (cnt_base != CNT_MAX)) cnt_next = cnt_base + CNT_W'(1);
    ovf_next = (clear ? 1'b0 : overflow) | (push && (cnt_next == CNT_MAX));
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig        <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push)       sig <= sig_upd;
      else if (clear) sig <= '0;
      word_count <= cnt_next;
      overflow   <= ovf_next;
    end
  end

endmodule
